// File: rtl/id_ex_alu_issue_if.sv
// ID/EX issue bus: ID-stage instruction fields, forwarding sources and EX-side ALU/control outputs.
interface id_ex_alu_issue_if;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [5:0]  id_opcode;
    logic [5:0]  id_funct;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [15:0] id_imm;
    logic        exmem_regwrite;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_regwrite;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic        ex_valid;
    logic [2:0]  alu_signal;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_dest;
    logic        ex_regwrite;
    logic        ex_memread;
    logic        ex_memwrite;
    logic        ex_branch;
    logic        ex_illegal;

    modport master (
        output stall, flush, id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd,
               id_rs_data, id_rt_data, id_imm,
               exmem_regwrite, exmem_rd, exmem_result,
               memwb_regwrite, memwb_rd, memwb_result,
        input  ex_valid, alu_signal, alu_a, alu_b, ex_store_data, ex_dest,
               ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_illegal
    );

    modport slave (
        input  stall, flush, id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd,
               id_rs_data, id_rt_data, id_imm,
               exmem_regwrite, exmem_rd, exmem_result,
               memwb_regwrite, memwb_rd, memwb_result,
        output ex_valid, alu_signal, alu_a, alu_b, ex_store_data, ex_dest,
               ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_illegal
    );
endinterface

// File: rtl/id_ex_alu_issue.sv
// ID/EX issue stage: decodes opcode/funct to the 3-bit ALU code, registers operands across
// the ID/EX boundary and resolves EX/MEM and MEM/WB forwarding onto the ALU inputs.
module id_ex_alu_issue (
    input logic               clk,
    input logic               rst,
    id_ex_alu_issue_if.slave  bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned SIG_W  = 3;
    localparam int unsigned IMM_W  = 16;

    localparam logic [SIG_W-1:0] ALU_AND = 3'b000;
    localparam logic [SIG_W-1:0] ALU_OR  = 3'b001;
    localparam logic [SIG_W-1:0] ALU_ADD = 3'b010;
    localparam logic [SIG_W-1:0] ALU_SUB = 3'b110;
    localparam logic [SIG_W-1:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_NOP = 6'b000000;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef struct packed {
        logic               valid;
        logic [SIG_W-1:0]   sig;
        logic               regwrite;
        logic               memread;
        logic               memwrite;
        logic               branch;
        logic               illegal;
        logic               b_imm;
        logic [DATA_W-1:0]  ext;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
        logic [REG_W-1:0]   dest;
        logic [DATA_W-1:0]  rs_data;
        logic [DATA_W-1:0]  rt_data;
    } ex_state_t;

    // Bubble: everything zero except the ALU code, which must stay a legal ADD.
    function automatic ex_state_t bubble();
        ex_state_t b;
        b     = '0;
        b.sig = ALU_ADD;
        return b;
    endfunction

    ex_state_t        ex_q;
    ex_state_t        ex_d;
    logic             sext;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    // Decode of the ID-stage instruction into the next EX state.
    always_comb begin
        ex_d = bubble();
        sext = 1'b1;
        if (bus.id_valid) begin
            ex_d.valid   = 1'b1;
            ex_d.rs      = bus.id_rs;
            ex_d.rt      = bus.id_rt;
            ex_d.rs_data = bus.id_rs_data;
            ex_d.rt_data = bus.id_rt_data;
            if (bus.id_opcode == OP_RTYPE) begin
                ex_d.dest = bus.id_rd;
                case (bus.id_funct)
                    FN_AND:  begin ex_d.sig = ALU_AND; ex_d.regwrite = 1'b1; end
                    FN_OR:   begin ex_d.sig = ALU_OR;  ex_d.regwrite = 1'b1; end
                    FN_ADD:  begin ex_d.sig = ALU_ADD; ex_d.regwrite = 1'b1; end
                    FN_SUB:  begin ex_d.sig = ALU_SUB; ex_d.regwrite = 1'b1; end
                    FN_SLT:  begin ex_d.sig = ALU_SLT; ex_d.regwrite = 1'b1; end
                    FN_NOP:  ex_d.sig = ALU_ADD;
                    default: ex_d.illegal = 1'b1;
                endcase
            end else begin
                case (bus.id_opcode)
                    OP_ADDI: begin
                        ex_d.b_imm = 1'b1; ex_d.regwrite = 1'b1; ex_d.dest = bus.id_rt;
                    end
                    OP_ANDI: begin
                        ex_d.sig = ALU_AND; sext = 1'b0;
                        ex_d.b_imm = 1'b1; ex_d.regwrite = 1'b1; ex_d.dest = bus.id_rt;
                    end
                    OP_ORI: begin
                        ex_d.sig = ALU_OR; sext = 1'b0;
                        ex_d.b_imm = 1'b1; ex_d.regwrite = 1'b1; ex_d.dest = bus.id_rt;
                    end
                    OP_SLTI: begin
                        ex_d.sig = ALU_SLT;
                        ex_d.b_imm = 1'b1; ex_d.regwrite = 1'b1; ex_d.dest = bus.id_rt;
                    end
                    OP_LW: begin
                        ex_d.b_imm = 1'b1; ex_d.regwrite = 1'b1; ex_d.memread = 1'b1;
                        ex_d.dest = bus.id_rt;
                    end
                    OP_SW: begin
                        ex_d.b_imm = 1'b1; ex_d.memwrite = 1'b1; ex_d.dest = bus.id_rt;
                    end
                    OP_BEQ: begin
                        ex_d.sig = ALU_SUB; ex_d.branch = 1'b1; ex_d.dest = bus.id_rt;
                    end
                    default: ex_d.illegal = 1'b1;
                endcase
            end
            ex_d.ext = sext ? {{(DATA_W-IMM_W){bus.id_imm[IMM_W-1]}}, bus.id_imm}
                            : {{(DATA_W-IMM_W){1'b0}}, bus.id_imm};
        end
    end

    // ID/EX register: flush beats stall, both lose to reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= bubble();
        end else if (bus.flush) begin
            ex_q <= bubble();
        end else if (!bus.stall) begin
            ex_q <= ex_d;
        end
    end

    // Forwarding re-resolves every cycle, so a stalled instruction still sees producers advance.
    always_comb begin
        fwd_rs = ex_q.rs_data;
        if (bus.exmem_regwrite && (bus.exmem_rd == ex_q.rs) && (ex_q.rs != '0)) begin
            fwd_rs = bus.exmem_result;
        end else if (bus.memwb_regwrite && (bus.memwb_rd == ex_q.rs) && (ex_q.rs != '0)) begin
            fwd_rs = bus.memwb_result;
        end
    end

    always_comb begin
        fwd_rt = ex_q.rt_data;
        if (bus.exmem_regwrite && (bus.exmem_rd == ex_q.rt) && (ex_q.rt != '0)) begin
            fwd_rt = bus.exmem_result;
        end else if (bus.memwb_regwrite && (bus.memwb_rd == ex_q.rt) && (ex_q.rt != '0)) begin
            fwd_rt = bus.memwb_result;
        end
    end

    assign bus.ex_valid      = ex_q.valid;
    assign bus.alu_signal    = ex_q.sig;
    assign bus.alu_a         = fwd_rs;
    assign bus.alu_b         = ex_q.b_imm ? ex_q.ext : fwd_rt;
    assign bus.ex_store_data = fwd_rt;
    assign bus.ex_dest       = ex_q.dest;
    assign bus.ex_regwrite   = ex_q.regwrite;
    assign bus.ex_memread    = ex_q.memread;
    assign bus.ex_memwrite   = ex_q.memwrite;
    assign bus.ex_branch     = ex_q.branch;
    assign bus.ex_illegal    = ex_q.illegal;
endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Scoreboard bench for id_ex_alu_issue: expected EX-side outputs are queued as stimulus is
// driven and popped against the DUT one cycle later (or immediately for forwarding/reset).
module tb_id_ex_alu_issue;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    id_ex_alu_issue_if bus ();

    id_ex_alu_issue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        valid;
        logic [2:0]  sig;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
        logic [4:0]  dest;
        logic        chk_dest;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        ill;
    } exp_t;

    exp_t sb[$];

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fails++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic v, input logic [2:0] s, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] sd, input logic [4:0] d,
                                input logic cd, input logic rw, input logic mr, input logic mw,
                                input logic br, input logic ill);
        exp_t e;
        e.valid = v; e.sig = s; e.a = a; e.b = b; e.sd = sd; e.dest = d; e.chk_dest = cd;
        e.rw = rw; e.mr = mr; e.mw = mw; e.br = br; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t bub();
        return mk(1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic check_out(input string tag);
        exp_t e;
        check({tag, "_pending"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_valid"}, 32'(bus.ex_valid), 32'(e.valid));
            check({tag, "_sig"},   32'(bus.alu_signal), 32'(e.sig));
            check({tag, "_a"},     bus.alu_a, e.a);
            check({tag, "_b"},     bus.alu_b, e.b);
            check({tag, "_sd"},    bus.ex_store_data, e.sd);
            if (e.chk_dest) check({tag, "_dest"}, 32'(bus.ex_dest), 32'(e.dest));
            check({tag, "_rw"},    32'(bus.ex_regwrite), 32'(e.rw));
            check({tag, "_mr"},    32'(bus.ex_memread), 32'(e.mr));
            check({tag, "_mw"},    32'(bus.ex_memwrite), 32'(e.mw));
            check({tag, "_br"},    32'(bus.ex_branch), 32'(e.br));
            check({tag, "_ill"},   32'(bus.ex_illegal), 32'(e.ill));
        end
    endtask

    task automatic tick_check(input string tag);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    task automatic set_id(input logic v, input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm);
        bus.id_valid = v; bus.id_opcode = op; bus.id_funct = fn;
        bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
        bus.id_rs_data = rsd; bus.id_rt_data = rtd; bus.id_imm = imm;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                           input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
        bus.exmem_regwrite = ew; bus.exmem_rd = erd; bus.exmem_result = eres;
        bus.memwb_regwrite = mw; bus.memwb_rd = mrd; bus.memwb_result = mres;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_id(1'b1, 6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 16'h0);

        // reset with a valid add held at ID
        sb.push_back(bub());
        #3 check_out("rst_async");
        sb.push_back(bub());
        tick_check("rst_hold");

        @(negedge clk) rst = 1'b0;
        sb.push_back(mk(1, 3'b010, 32'h5, 32'h7, 32'h7, 5'd3, 1, 1, 0, 0, 0, 0));
        tick_check("add");

        @(negedge clk) set_id(1'b1, 6'b000000, 6'b100010, 5'd4, 5'd6, 5'd9, 32'hA, 32'h3, 16'h0);
        sb.push_back(mk(1, 3'b110, 32'hA, 32'h3, 32'h3, 5'd9, 1, 1, 0, 0, 0, 0));
        tick_check("sub");

        @(negedge clk) set_id(1'b1, 6'b001010, 6'h0, 5'd1, 5'd8, 5'd0, 32'h2, 32'h55, 16'hFFFF);
        sb.push_back(mk(1, 3'b111, 32'h2, 32'hFFFFFFFF, 32'h55, 5'd8, 1, 1, 0, 0, 0, 0));
        tick_check("slti");

        @(negedge clk) set_id(1'b1, 6'b001101, 6'h0, 5'd1, 5'd8, 5'd0, 32'h2, 32'h55, 16'hFFFF);
        sb.push_back(mk(1, 3'b001, 32'h2, 32'h0000FFFF, 32'h55, 5'd8, 1, 1, 0, 0, 0, 0));
        tick_check("ori");

        @(negedge clk) set_id(1'b1, 6'b100011, 6'h0, 5'd2, 5'd10, 5'd0, 32'h100, 32'h0, 16'h8000);
        sb.push_back(mk(1, 3'b010, 32'h100, 32'hFFFF8000, 32'h0, 5'd10, 1, 1, 1, 0, 0, 0));
        tick_check("lw");

        // sw: store data comes through the EX/MEM forward, b stays the immediate
        @(negedge clk);
        set_id(1'b1, 6'b101011, 6'h0, 5'd2, 5'd3, 5'd0, 32'h100, 32'h77, 16'h0004);
        set_fwd(1'b1, 5'd3, 32'hBEEF, 1'b0, 5'd0, 32'h0);
        sb.push_back(mk(1, 3'b010, 32'h100, 32'h4, 32'hBEEF, 5'd3, 1, 0, 0, 1, 0, 0));
        tick_check("sw");

        @(negedge clk);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_id(1'b1, 6'b001100, 6'h0, 5'd2, 5'd4, 5'd0, 32'hFF00FF00, 32'h0, 16'h8001);
        sb.push_back(mk(1, 3'b000, 32'hFF00FF00, 32'h00008001, 32'h0, 5'd4, 1, 1, 0, 0, 0, 0));
        tick_check("andi");

        // forwarding priority, re-resolved without a clock edge
        @(negedge clk);
        set_id(1'b1, 6'b000000, 6'b100101, 5'd5, 5'd7, 5'd1, 32'h99, 32'h44, 16'h0);
        set_fwd(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
        sb.push_back(mk(1, 3'b001, 32'h11, 32'h44, 32'h44, 5'd1, 1, 1, 0, 0, 0, 0));
        tick_check("fwd_exmem");
        set_fwd(1'b0, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22);
        sb.push_back(mk(1, 3'b001, 32'h22, 32'h44, 32'h44, 5'd1, 1, 1, 0, 0, 0, 0));
        #1 check_out("fwd_memwb");
        set_fwd(1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22);
        sb.push_back(mk(1, 3'b001, 32'h99, 32'h44, 32'h44, 5'd1, 1, 1, 0, 0, 0, 0));
        #1 check_out("fwd_rd0");
        set_fwd(1'b1, 5'd7, 32'h66, 1'b1, 5'd7, 32'h33);
        sb.push_back(mk(1, 3'b001, 32'h99, 32'h66, 32'h66, 5'd1, 1, 1, 0, 0, 0, 0));
        #1 check_out("fwd_rt_prio");
        set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h33);
        sb.push_back(mk(1, 3'b001, 32'h99, 32'h33, 32'h33, 5'd1, 1, 1, 0, 0, 0, 0));
        #1 check_out("fwd_rt_memwb");

        // index 0 is never forwarded even with regwrite and rd=0
        @(negedge clk);
        set_id(1'b1, 6'b000000, 6'b100000, 5'd0, 5'd0, 5'd4, 32'h123, 32'h456, 16'h0);
        set_fwd(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
        sb.push_back(mk(1, 3'b010, 32'h123, 32'h456, 32'h456, 5'd4, 1, 1, 0, 0, 0, 0));
        tick_check("fwd_idx0");

        // stall holds `and` in EX; forwarding still tracks
        @(negedge clk);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_id(1'b1, 6'b000000, 6'b100100, 5'd5, 5'd6, 5'd2, 32'hF0, 32'h0F, 16'h0);
        sb.push_back(mk(1, 3'b000, 32'hF0, 32'h0F, 32'h0F, 5'd2, 1, 1, 0, 0, 0, 0));
        tick_check("and");
        @(negedge clk);
        bus.stall = 1'b1;
        set_id(1'b1, 6'b000000, 6'b100010, 5'd9, 5'd9, 5'd9, 32'h1, 32'h1, 16'h0);
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk(1, 3'b000, 32'hF0, 32'h0F, 32'h0F, 5'd2, 1, 1, 0, 0, 0, 0));
            tick_check($sformatf("stall%0d", i));
        end
        set_fwd(1'b1, 5'd5, 32'hABC, 1'b0, 5'd0, 32'h0);
        sb.push_back(mk(1, 3'b000, 32'hABC, 32'h0F, 32'h0F, 5'd2, 1, 1, 0, 0, 0, 0));
        #1 check_out("stall_fwd");

        @(negedge clk);
        bus.flush = 1'b1;
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        sb.push_back(bub());
        tick_check("stall_flush");

        @(negedge clk);
        bus.stall = 1'b0;
        set_id(1'b1, 6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 16'h0);
        sb.push_back(bub());
        tick_check("flush");

        @(negedge clk);
        bus.flush = 1'b0;
        bus.id_valid = 1'b0;
        sb.push_back(bub());
        tick_check("id_invalid");

        @(negedge clk) set_id(1'b1, 6'b000000, 6'b000000, 5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 16'h0);
        sb.push_back(mk(1, 3'b010, 32'h5, 32'h7, 32'h7, 5'd0, 0, 0, 0, 0, 0, 0));
        tick_check("nop");

        @(negedge clk) set_id(1'b1, 6'b111111, 6'h0, 5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 16'h1234);
        sb.push_back(mk(1, 3'b010, 32'h5, 32'h7, 32'h7, 5'd0, 0, 0, 0, 0, 0, 1));
        tick_check("ill_op");

        @(negedge clk) set_id(1'b1, 6'b000000, 6'b000111, 5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 16'h0);
        sb.push_back(mk(1, 3'b010, 32'h5, 32'h7, 32'h7, 5'd0, 0, 0, 0, 0, 0, 1));
        tick_check("ill_fn");

        @(negedge clk) set_id(1'b1, 6'b000100, 6'h0, 5'd1, 5'd2, 5'd0, 32'h5, 32'h7, 16'h0010);
        sb.push_back(mk(1, 3'b110, 32'h5, 32'h7, 32'h7, 5'd2, 1, 0, 0, 0, 1, 0));
        tick_check("beq");

        // async reset mid-instruction discards it immediately
        @(negedge clk) set_id(1'b1, 6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3, 32'h5, 32'h7, 16'h0);
        sb.push_back(mk(1, 3'b010, 32'h5, 32'h7, 32'h7, 5'd3, 1, 1, 0, 0, 0, 0));
        tick_check("pre_rst");
        #3 rst = 1'b1;
        sb.push_back(bub());
        #1 check_out("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        bus.id_valid = 1'b0;
        sb.push_back(bub());
        tick_check("post_rst");

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
